clk_div_prog: RTL and testbench

- Runtime-programmable integer clock divider. It generalises the fixed divide-by-4 block to any ratio N in 2..2^CNT_W-1, with even or odd N.
- Produces a registered divided clock-enable waveform (clk_out) and a one-cycle tick at each period start.
- Divisor changes are glitch-free: a new N takes effect only at a period boundary.
- Used as a shared timing source for slow peripherals (LED scan, UART baud base, sample strobes) in the single-clock fabric.

---
 rtl/clk_div_prog.sv | 91 +++++++++
 tb/tb_clk_div_prog.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider: registered clk_out waveform, period-start tick,
// and divisor changes that take effect only at period boundaries.
module clk_div_prog #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic [CNT_W-1:0] div_cur,
    output logic             div_err
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(2);

    generate
        if (DEFAULT_DIV < 2 || DEFAULT_DIV > (2 ** CNT_W) - 1) begin : g_bad_default_div
            $error("clk_div_prog: DEFAULT_DIV must lie in 2..2^CNT_W-1");
        end
    endgenerate

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] pending;
    logic             run;
    logic             pend_vld;

    logic [CNT_W:0]   cnt_inc;
    logic [CNT_W-1:0] half;
    logic             boundary;
    logic             load_ok;
    logic             load_bad;

    // cnt+1 carries an extra bit so N = 2^CNT_W-1 compares without overflow
    assign cnt_inc  = {1'b0, cnt} + 1'b1;
    assign half     = div_cur >> 1;
    assign boundary = en && (!run || (cnt_inc == {1'b0, div_cur}));
    assign load_ok  = div_load && (div_val >= DIV_MIN);
    assign load_bad = div_load && (div_val < DIV_MIN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            run      <= 1'b0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
            div_err  <= 1'b0;
            div_cur  <= DIV_RST;
            pend_vld <= 1'b0;
        end else begin
            div_err <= load_bad;

            // A boundary consumes the value pending before this edge; a same-edge load re-arms it
            if (boundary && pend_vld) begin
                div_cur  <= pending;
                pend_vld <= 1'b0;
            end
            if (load_ok) begin
                pend_vld <= 1'b1;
            end

            if (!en) begin
                run     <= 1'b0;
                cnt     <= '0;
                clk_out <= 1'b0;
                tick    <= 1'b0;
            end else if (boundary) begin
                run     <= 1'b1;
                cnt     <= '0;
                clk_out <= 1'b1;
                tick    <= 1'b1;
            end else begin
                cnt     <= cnt_inc[CNT_W-1:0];
                clk_out <= (cnt_inc < {1'b0, half});
                tick    <= 1'b0;
            end
        end
    end

    // Pending divisor is only meaningful while pend_vld is set, so it carries no reset
    always_ff @(posedge clk) begin
        if (load_ok) begin
            pending <= div_val;
        end
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: waveform shape, tick alignment, divisor load timing,
// rejected loads, wide divisor and mid-period reset.
module tb_clk_div_prog;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] div_val;
    logic       div_load;
    logic       clk_out;
    logic       tick;
    logic [7:0] div_cur;
    logic       div_err;

    int n_cmp = 0;
    int n_bad = 0;

    clk_div_prog #(.CNT_W(8), .DEFAULT_DIV(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .div_val (div_val),
        .div_load(div_load),
        .clk_out (clk_out),
        .tick    (tick),
        .div_cur (div_cur),
        .div_err (div_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Check ncyc cycles of an N-cycle period starting at phase sp, advancing one clock after each
    task automatic chk_wave(input int n, input int sp, input int ncyc);
        int ph;
        for (int i = 0; i < ncyc; i++) begin
            ph = (sp + i) % n;
            chk_eq($sformatf("clk_out N=%0d ph=%0d", n, ph), 32'(clk_out), 32'(ph < (n / 2)));
            chk_eq($sformatf("tick N=%0d ph=%0d", n, ph), 32'(tick), 32'(ph == 0));
            chk_eq($sformatf("div_cur N=%0d ph=%0d", n, ph), 32'(div_cur), 32'(n));
            step();
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        div_val  = 8'd0;
        div_load = 1'b0;
        step();
        step();
        chk_eq("rst clk_out", 32'(clk_out), 32'd0);
        chk_eq("rst tick", 32'(tick), 32'd0);
        chk_eq("rst div_cur", 32'(div_cur), 32'd4);
        chk_eq("rst div_err", 32'(div_err), 32'd0);

        // Idle after reset stays low
        rst_n = 1'b1;
        step();
        chk_eq("idle clk_out", 32'(clk_out), 32'd0);
        chk_eq("idle tick", 32'(tick), 32'd0);

        // Default divide-by-4, first high right after en is sampled
        en = 1'b1;
        step();
        chk_wave(4, 0, 12);

        // Load 5 mid-period: current 4-cycle period completes first
        chk_wave(4, 0, 2);
        div_val  = 8'd5;
        div_load = 1'b1;
        step();
        div_load = 1'b0;
        chk_wave(4, 3, 1);
        chk_wave(5, 0, 10);

        // Load 3 then 7 in one period: only 7 lands
        chk_wave(5, 0, 1);
        div_val  = 8'd3;
        div_load = 1'b1;
        step();
        div_val  = 8'd7;
        step();
        div_load = 1'b0;
        chk_wave(5, 3, 2);
        chk_wave(7, 0, 14);

        // Rejected loads: div_err pulses, divisor and waveform untouched
        chk_wave(7, 0, 1);
        div_val  = 8'd1;
        div_load = 1'b1;
        step();
        chk_eq("div_err val1", 32'(div_err), 32'd1);
        div_val = 8'd0;
        step();
        chk_eq("div_err val0", 32'(div_err), 32'd1);
        div_load = 1'b0;
        step();
        chk_eq("div_err clear", 32'(div_err), 32'd0);
        chk_wave(7, 4, 10);

        // Pending 6, then load 2 on the exact wrap edge: 6 first, 2 after
        chk_wave(7, 0, 1);
        div_val  = 8'd6;
        div_load = 1'b1;
        step();
        div_load = 1'b0;
        chk_wave(7, 2, 4);
        div_val  = 8'd2;
        div_load = 1'b1;
        chk_wave(7, 6, 1);
        div_load = 1'b0;
        chk_wave(6, 0, 6);
        chk_wave(2, 0, 6);

        // Widest divisor: 127 high / 128 low, tick every 255
        div_val  = 8'd255;
        div_load = 1'b1;
        chk_wave(2, 0, 1);
        div_load = 1'b0;
        chk_wave(2, 1, 1);
        chk_wave(255, 0, 510);
        chk_wave(255, 0, 100);

        // Reset mid-period aborts immediately
        rst_n = 1'b0;
        step();
        chk_eq("midrst clk_out", 32'(clk_out), 32'd0);
        chk_eq("midrst tick", 32'(tick), 32'd0);
        chk_eq("midrst div_cur", 32'(div_cur), 32'd4);
        chk_eq("midrst div_err", 32'(div_err), 32'd0);
        rst_n = 1'b1;
        step();
        chk_wave(4, 0, 6);

        // en dropping mid-period truncates; restart is a fresh period
        en = 1'b0;
        step();
        chk_eq("en drop clk_out", 32'(clk_out), 32'd0);
        chk_eq("en drop tick", 32'(tick), 32'd0);
        en = 1'b1;
        step();
        chk_wave(4, 0, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
